// File: rtl/mul4_pkg.sv
// Shared constants and FSM state type for the 4x4 multiply table builder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul4_pkg;

    localparam int OPW    = 4;
    localparam int ADDR_W = 2 * OPW;
    localparam int DEPTH  = 1 << ADDR_W;

    // Fill sequencer states; IDLE and DONE are the only states that accept start.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_256x8.sv
// Simple dual-port table RAM: one synchronous write port, one registered read port.
// Latency: read data appears 1 cycle after raddr is sampled; writes land on the edge.
// Backpressure: none; both ports accept every cycle. Array is not reset.
module ram_256x8
    import mul4_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = ADDR_W
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // Write port and registered read port; read returns pre-write data on a collision.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mul4_table_fill.sv
// Builds the x*y lookup table with a shift-add multiplier, then serves registered lookups.
// Latency: fill takes 1280 cycles after start; lookups return 1 cycle after mul is sampled.
// Backpressure: start is ignored while busy; mul_r reads 0 while busy or straight after reset.
module mul4_table_fill
    import mul4_pkg::*;
#(
    parameter int OPW = mul4_pkg::OPW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [2*OPW-1:0]  mul,
    output logic [2*OPW-1:0]  mul_r
);

    localparam int AW = 2 * OPW;
    localparam int BW = $clog2(OPW);

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   r_acc;
    logic [BW-1:0]   r_bit;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_en;

    logic [OPW-1:0]  w_x;
    logic [OPW-1:0]  w_y;
    logic [AW-1:0]   w_pp;
    logic            w_we;
    logic [AW-1:0]   w_rdata;

    assign w_x = r_cnt[AW-1:OPW];
    assign w_y = r_cnt[OPW-1:0];

    // Partial product for the current multiplier bit: x shifted into place when y[i] is set.
    always_comb begin
        w_pp = '0;
        if (w_y[r_bit]) begin
            w_pp = {{OPW{1'b0}}, w_x} << r_bit;
        end
    end

    assign w_we = (r_state == S_WRITE);

    // Fill sequencer: walks every entry, runs OPW shift-add steps, then writes the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_rd_en <= 1'b1;
                    if (start) begin
                        r_state <= S_MUL;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_bit   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_rd_en <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_acc <= r_acc + w_pp;
                    r_bit <= r_bit + 1'b1;
                    if (r_bit == BW'(OPW - 1)) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_cnt == {AW{1'b1}}) begin
                        // Reads re-open one edge later so the last write is never read stale.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_MUL;
                        r_cnt   <= r_cnt + 1'b1;
                        r_acc   <= '0;
                        r_bit   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    ram_256x8 #(
        .AW (AW),
        .DW (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_cnt),
        .i_wdata (r_acc),
        .i_raddr (mul),
        .o_rdata (w_rdata)
    );

    assign busy  = r_busy;
    assign done  = r_done;
    assign mul_r = r_rd_en ? w_rdata : '0;

endmodule

// File: tb/tb_mul4_table_fill.sv
// Randomized self-checking bench for mul4_table_fill against an arithmetic product table.
// Latency: fill expected 1280 edges after the start edge; lookups 1 edge.
// Backpressure: exercises ignored start while busy and reads gated to 0 while busy.
module tb_mul4_table_fill;

    localparam int FILL_EDGES = 1280;
    localparam int WAIT_LIMIT = 1500;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] mul;
    logic [7:0] mul_r;

    int n_chk = 0;
    int n_err = 0;
    int ref_tab [256];

    always #5 clk = ~clk;

    mul4_table_fill dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .mul   (mul),
        .mul_r (mul_r)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start is sampled on the next edge (t0); returns just after t0.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // done becomes visible in the cycle labelled t0+1281, i.e. after edge t0+1280.
    task automatic wait_done(input int already, input string tag);
        int n;
        n = already;
        while (!done && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        chk(tag, n, FILL_EDGES);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic lookup(input string tag, input int addr);
        mul = addr[7:0];
        tick();
        chk($sformatf("%s_%02h", tag, addr), mul_r, ref_tab[addr]);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 256; a++) begin
            lookup(tag, a);
        end
    endtask

    task automatic rand_lookups(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            lookup(tag, int'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        int n;

        for (int a = 0; a < 256; a++) begin
            ref_tab[a] = (a / 16) * (a % 16);
        end

        // Reset takes effect with no clock edge.
        rst   = 1'b1;
        start = 1'b0;
        mul   = 8'h00;
        #1;
        chk("rst_busy",  busy,  1'b0);
        chk("rst_done",  done,  1'b0);
        chk("rst_mul_r", mul_r, 8'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);

        // First fill: reads gated while busy, second start ignored.
        mul = 8'hFF;
        pulse_start();
        chk("fill_busy", busy, 1'b1);
        chk("fill_done", done, 1'b0);
        repeat (50) tick();
        chk("busy_mul_r", mul_r, 8'd0);
        repeat (49) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 100;
        chk("restart_busy",  busy,  1'b1);
        chk("restart_mul_r", mul_r, 8'd0);
        wait_done(n, "done_lat1");

        // Spot lookups with hand-computed products.
        mul = 8'h00; tick(); chk("lk_00", mul_r, 8'd0);
        mul = 8'hFF; tick(); chk("lk_FF", mul_r, 8'd225);
        mul = 8'h37; tick(); chk("lk_37", mul_r, 8'd21);
        mul = 8'hA5; tick(); chk("lk_A5", mul_r, 8'd50);
        mul = 8'h1F; tick(); chk("lk_1F", mul_r, 8'd15);

        sweep("sw1");
        rand_lookups("rnd1", 64);

        // Asynchronous reset in the middle of a fill.
        pulse_start();
        repeat (599) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  busy,  1'b0);
        chk("mid_rst_done",  done,  1'b0);
        chk("mid_rst_mul_r", mul_r, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        wait_done(0, "done_lat2");
        sweep("sw2");

        // Refill from DONE.
        pulse_start();
        chk("refill_done", done, 1'b0);
        chk("refill_busy", busy, 1'b1);
        wait_done(0, "done_lat3");
        sweep("sw3");
        rand_lookups("rnd3", 32);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
